// File: rtl/gray_counter.sv
// Registered up/down counter presenting both the binary count and its Gray
// encoding, with binary or Gray-coded synchronous load and wrap/saturate ends.
module gray_counter #(
    parameter int WIDTH     = 4,
    parameter bit WRAP_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONE = '1;
    localparam logic [WIDTH-1:0] ZERO    = '0;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_nxt;
    logic             wrap_nxt;
    logic             at_max;
    logic             at_min;

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign load_bin = load_gray ? gray_to_bin(load_val) : load_val;
    assign at_max   = (bin_out == ALL_ONE);
    assign at_min   = (bin_out == ZERO);

    always_comb begin
        bin_nxt  = bin_out;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_bin;
        end else if (en) begin
            if (up_dn) begin
                if (!at_max) begin
                    bin_nxt = bin_out + ONE;
                end else if (WRAP_MODE) begin
                    bin_nxt  = ZERO;
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    bin_nxt = bin_out - ONE;
                end else if (WRAP_MODE) begin
                    bin_nxt  = ALL_ONE;
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    // Gray is encoded from the next count so both outputs change on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_out  <= ZERO;
            gray_out <= ZERO;
            wrap     <= 1'b0;
        end else begin
            bin_out  <= bin_nxt;
            gray_out <= bin_nxt ^ (bin_nxt >> 1);
            wrap     <= wrap_nxt;
        end
    end

endmodule
